// File: rtl/i2s_transmit_24.sv
// ---------------------------------------------------------------------------
// i2s_transmit_24
//
// Purpose:
//   I2S transmitter. Stereo sample pairs arrive on a valid/ready handshake,
//   wait in a one-entry holding register, move into the active frame
//   register at the start of each left slot, and are serialised MSB-first
//   onto sd_o. The bit clock (sck_i) and word select (ws_i) come from an
//   external clock generator and are sampled in the clk_i domain. Each slot
//   follows the I2S one-SCK delay: the first bit after a ws edge is a pad
//   bit, and the MSB follows on the next SCK.
//
// Ports:
//   clk_i       in   1       system clock, sole clock
//   rst_i       in   1       synchronous active-high reset
//   sck_i       in   1       I2S bit clock, synchronous to clk_i
//   ws_i        in   1       I2S word select (0 = left, 1 = right)
//   left_i      in   DATA_W  left sample, two's complement
//   right_i     in   DATA_W  right sample
//   valid_i     in   1       sample pair valid
//   ready_o     out  1       holding register empty
//   sd_o        out  1       serial data to DAC
//   underrun_o  out  1       one-clk pulse: left slot started with no pair
//
// Parameters:
//   DATA_W    bits per channel word
//   PAD_ZERO  1: pad bits are 0; 0: pad bits repeat the last driven bit
// ---------------------------------------------------------------------------
module i2s_transmit_24 #(
    parameter int DATA_W   = 24,
    parameter bit PAD_ZERO = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sck_i,
    input  logic              ws_i,
    input  logic [DATA_W-1:0] left_i,
    input  logic [DATA_W-1:0] right_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              sd_o,
    output logic              underrun_o
);

    // Counter must hold the value DATA_W itself (bits still to send).
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic              sck_q;          // sck_i delayed one clk, for edge detect
    logic              ws_last_q;      // ws_i as sampled on the previous fall
    logic              synced_q;       // ws_last_q holds a valid reference
    logic [DATA_W-1:0] hold_left_q;    // holding register, left word
    logic [DATA_W-1:0] hold_right_q;   // holding register, right word
    logic              hold_full_q;
    logic              ready_q;
    logic [DATA_W-1:0] active_right_q; // right word of the frame on the wire
    logic [DATA_W-1:0] shift_q;        // word being serialised, MSB first
    logic [CNT_W-1:0]  bitcnt_q;       // data bits still to send this slot
    logic              sd_q;
    logic              underrun_q;

    logic              ws_last_d;
    logic              synced_d;
    logic [DATA_W-1:0] hold_left_d;
    logic [DATA_W-1:0] hold_right_d;
    logic              hold_full_d;
    logic              ready_d;
    logic [DATA_W-1:0] active_right_d;
    logic [DATA_W-1:0] shift_d;
    logic [CNT_W-1:0]  bitcnt_d;
    logic              sd_d;
    logic              underrun_d;

    // -----------------------------------------------------------------------
    // Edge and boundary decode
    // -----------------------------------------------------------------------
    logic fall;
    logic boundary;
    logic left_boundary;
    logic right_boundary;
    logic accept;
    logic pad_bit;

    always_comb begin
        fall           = sck_q & ~sck_i;
        // A boundary needs a trusted reference, so the first fall after reset
        // (which only captures ws) can never be one.
        boundary       = fall & synced_q & (ws_i != ws_last_q);
        left_boundary  = boundary & ~ws_i;
        right_boundary = boundary & ws_i;
        accept         = valid_i & ready_q;
        pad_bit        = PAD_ZERO ? 1'b0 : sd_q;
    end

    // -----------------------------------------------------------------------
    // Word-select tracking
    // -----------------------------------------------------------------------
    always_comb begin
        ws_last_d = ws_last_q;
        synced_d  = synced_q;
        if (fall) begin
            ws_last_d = ws_i;
            synced_d  = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Holding register, active frame register and handshake
    // -----------------------------------------------------------------------
    always_comb begin
        hold_left_d    = hold_left_q;
        hold_right_d   = hold_right_q;
        hold_full_d    = hold_full_q;
        active_right_d = active_right_q;
        underrun_d     = 1'b0;

        if (left_boundary) begin
            if (hold_full_q) begin
                active_right_d = hold_right_q;
                hold_left_d    = '0;
                hold_right_d   = '0;
                hold_full_d    = 1'b0;
            end else begin
                // Nothing queued: the whole frame goes out as silence.
                active_right_d = '0;
                underrun_d     = 1'b1;
            end
        end

        // ready_q is ~hold_full_q, so an accept never coincides with the
        // hold-to-active move above; a pair offered in that clk waits until
        // ready_o rises on the following clk.
        if (accept) begin
            hold_left_d  = left_i;
            hold_right_d = right_i;
            hold_full_d  = 1'b1;
        end

        ready_d = ~hold_full_d;
    end

    // -----------------------------------------------------------------------
    // Serialiser
    // -----------------------------------------------------------------------
    always_comb begin
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        sd_d     = sd_q;

        if (boundary) begin
            // One-SCK delay: the slot opens with a pad bit while the new word
            // is loaded. Any bits left over from a short slot are dropped.
            sd_d     = pad_bit;
            bitcnt_d = CNT_LOAD;
            if (left_boundary) begin
                shift_d = hold_full_q ? hold_left_q : '0;
            end else if (right_boundary) begin
                shift_d = active_right_q;
            end
        end else if (fall && synced_q) begin
            if (bitcnt_q != '0) begin
                sd_d     = shift_q[DATA_W-1];
                shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                bitcnt_d = bitcnt_q - CNT_ONE;
            end else begin
                // Long slot: keep padding until the next boundary.
                sd_d = pad_bit;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // The edge detector keeps tracking sck through reset so the first
        // fall after release is seen correctly.
        sck_q <= sck_i;
        if (rst_i) begin
            ws_last_q      <= 1'b0;
            synced_q       <= 1'b0;
            hold_left_q    <= '0;
            hold_right_q   <= '0;
            hold_full_q    <= 1'b0;
            ready_q        <= 1'b1;
            active_right_q <= '0;
            shift_q        <= '0;
            bitcnt_q       <= '0;
            sd_q           <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            ws_last_q      <= ws_last_d;
            synced_q       <= synced_d;
            hold_left_q    <= hold_left_d;
            hold_right_q   <= hold_right_d;
            hold_full_q    <= hold_full_d;
            ready_q        <= ready_d;
            active_right_q <= active_right_d;
            shift_q        <= shift_d;
            bitcnt_q       <= bitcnt_d;
            sd_q           <= sd_d;
            underrun_q     <= underrun_d;
        end
    end

    assign ready_o    = ready_q;
    assign sd_o       = sd_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_transmit_24.sv
// ---------------------------------------------------------------------------
// tb_i2s_transmit_24
//
// Drives sck/ws like an I2S clock generator (sck period 8 clk), pushes sample
// pairs, and checks sd_o with an I2S receiver model that samples on sck rise.
// A frame-level reference model turns accepted pairs into expected slot words
// (or silence plus an underrun pulse) at every left ws edge; the receiver
// pops them as complete slots arrive.
// ---------------------------------------------------------------------------
module tb_i2s_transmit_24;

    localparam int DATA_W = 24;
    localparam int HALF   = 4;      // clk cycles per sck phase

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sck = 1'b0;
    logic              ws  = 1'b1;
    logic [DATA_W-1:0] left_in  = '0;
    logic [DATA_W-1:0] right_in = '0;
    logic              valid = 1'b0;
    logic              ready;
    logic              sd;
    logic              under;

    i2s_transmit_24 #(.DATA_W(DATA_W), .PAD_ZERO(1'b1)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sck_i      (sck),
        .ws_i       (ws),
        .left_i     (left_in),
        .right_i    (right_in),
        .valid_i    (valid),
        .ready_o    (ready),
        .sd_o       (sd),
        .underrun_o (under)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // sck / ws generator: ws toggles together with an sck fall every
    // slot_len bit clocks.
    // -----------------------------------------------------------------------
    int slot_len = 32;
    int gen_cnt  = 0;

    initial begin
        forever begin
            @(negedge clk);
            sck = 1'b1;
            repeat (HALF - 1) @(negedge clk);
            @(negedge clk);
            sck = 1'b0;
            gen_cnt++;
            if (gen_cnt >= slot_len) begin
                ws      = ~ws;
                gen_cnt = 0;
            end
            repeat (HALF - 1) @(negedge clk);
        end
    end

    // -----------------------------------------------------------------------
    // Reference model (frame level)
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] hold_l[$];
    logic [DATA_W-1:0] hold_r[$];
    logic [DATA_W-1:0] exp_q[$];
    bit m_sck_prev    = 1'b0;
    bit m_synced      = 1'b0;
    bit m_ws          = 1'b0;
    bit m_fell        = 1'b0;
    bit m_ready_prev  = 1'b1;
    bit exp_under_now = 1'b0;
    bit rst_at_edge   = 1'b0;
    int left_events   = 0;
    int reset_events  = 0;

    initial begin
        forever begin
            @(posedge clk);
            m_fell        = m_sck_prev && !sck;
            m_sck_prev    = sck;
            exp_under_now = 1'b0;
            if (rst) begin
                rst_at_edge = 1'b1;
                hold_l.delete();
                hold_r.delete();
                exp_q.delete();
                m_synced = 1'b0;
                reset_events++;
            end else begin
                rst_at_edge  = 1'b0;
                m_ready_prev = (hold_l.size() == 0);
                if (m_fell) begin
                    if (!m_synced) begin
                        m_synced = 1'b1;
                    end else if (ws != m_ws && ws == 1'b0) begin
                        if (hold_l.size() > 0) begin
                            exp_q.push_back(hold_l.pop_front());
                            exp_q.push_back(hold_r.pop_front());
                        end else begin
                            exp_q.push_back('0);
                            exp_q.push_back('0);
                            exp_under_now = 1'b1;
                        end
                        left_events++;
                    end
                    m_ws = ws;
                end
                if (valid && m_ready_prev) begin
                    hold_l.push_back(left_in);
                    hold_r.push_back(right_in);
                    $display("accept L=%06h R=%06h at %0t", left_in, right_in, $time);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-clk checks: reset values, ready_o, underrun_o timing
    // -----------------------------------------------------------------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_at_edge) begin
                chk("rst_sd", sd, 0);
                chk("rst_ready", ready, 1);
                chk("rst_underrun", under, 0);
            end else begin
                chk("ready", ready, (hold_l.size() == 0) ? 1 : 0);
                chk("underrun", under, exp_under_now);
            end
        end
    end

    // -----------------------------------------------------------------------
    // I2S receiver monitor (samples sd on sck rise) and scoreboard
    // -----------------------------------------------------------------------
    bit          mon_in_slot   = 1'b0;
    bit          mon_ws        = 1'b0;
    bit          mon_checked   = 1'b0;
    bit          mon_frame_chk = 1'b0;
    logic [63:0] mon_bits      = '0;
    logic [63:0] mon_exp       = '0;
    logic [DATA_W-1:0] mon_word = '0;
    int          mon_nb        = 0;
    int          mon_rst_seen  = 0;
    int          mon_consumed  = 0;

    initial begin
        forever begin
            @(posedge sck);
            if (rst || mon_rst_seen != reset_events) begin
                mon_rst_seen  = reset_events;
                mon_consumed  = left_events;
                mon_in_slot   = 1'b0;
                mon_frame_chk = 1'b0;
                mon_ws        = ws;
            end else if (mon_in_slot && ws == mon_ws) begin
                mon_bits = {mon_bits[62:0], sd};
                mon_nb++;
            end else if (!mon_in_slot && ws == mon_ws) begin
                chk("idle_sd", sd, 0);
            end else begin
                if (mon_in_slot) begin
                    if (mon_checked) begin
                        if (exp_q.size() == 0) begin
                            chk("exp_available", 0, 1);
                        end else begin
                            mon_word = exp_q.pop_front();
                            mon_exp  = '0;
                            for (int k = 1; k <= mon_nb; k++) begin
                                mon_exp = {mon_exp[62:0],
                                           (k >= 2 && k <= DATA_W + 1) ? mon_word[DATA_W + 1 - k] : 1'b0};
                            end
                            chk(mon_ws ? "right_slot" : "left_slot", mon_bits, mon_exp);
                            $display("slot %s %0d bits word=%06h at %0t",
                                     mon_ws ? "R" : "L", mon_nb, mon_word, $time);
                        end
                    end else begin
                        chk("silent_slot", mon_bits, 0);
                    end
                end
                // New slot starts with this rise.
                mon_ws      = ws;
                mon_in_slot = 1'b1;
                mon_bits    = {63'b0, sd};
                mon_nb      = 1;
                if (ws == 1'b0) begin
                    mon_checked   = (left_events != mon_consumed);
                    mon_consumed  = left_events;
                    mon_frame_chk = mon_checked;
                end else begin
                    mon_checked   = mon_frame_chk;
                    mon_frame_chk = 1'b0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic send_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        bit acc;
        @(negedge clk);
        left_in  = l;
        right_in = r;
        valid    = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < 4000 && !acc; i++) begin
            @(posedge clk);
            if (ready) acc = 1'b1;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int le;
        bit seen;
        // Reset, 3 clks with sck running.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single pair before the first left boundary.
        send_pair(24'hA5A5A5, 24'h3C3C3C);
        idle(3 * 512);

        // Backpressure: valid held across three pairs.
        send_pair(24'h000001, 24'h000002);
        send_pair(24'h000003, 24'h000004);
        send_pair(24'h000005, 24'h000006);
        idle(4 * 512);

        // Underrun then one pair.
        idle(2 * 512);
        send_pair(24'h7FFFFF, 24'h800000);
        idle(3 * 512);

        // Randomised pairs with random gaps.
        for (int i = 0; i < 8; i++) begin
            send_pair(DATA_W'($urandom), DATA_W'($urandom));
            idle($urandom_range(0, 700));
        end
        idle(3 * 512);

        // Short slots: 16 SCK per slot.
        slot_len = 16;
        idle(3 * 256);
        send_pair(24'h800001, 24'h00F00F);
        idle(4 * 256);
        slot_len = 32;
        idle(2 * 512);

        // Reset mid-word during left bit 10 of 0xFFFFFF, hold full.
        send_pair(24'hFFFFFF, 24'h123456);
        le   = left_events;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (left_events != le) seen = 1'b1;
        end
        if (!seen) chk("boundary_timeout", 0, 1);
        send_pair(24'h111111, 24'h222222);
        @(negedge clk);
        valid = 1'b0;
        repeat (10) @(negedge sck);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(3 * 512);
        send_pair(24'h654321, 24'hABCDEF);
        idle(3 * 512);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
